// File: rtl/periph_bus_ctrl_pkg.sv
// periph_bus_ctrl_pkg: FSM state encoding and slave indices shared by the peripheral bus controller.
package periph_bus_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
  localparam int SLV_DMEM   = 0;
  localparam int SLV_UART0  = 1;
  localparam int SLV_GPIO0  = 2;
  localparam int NUM_SLAVES = 3;
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: counts ACCESS cycles and flags the cycle whose edge reaches TIMEOUT_CYCLES.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // the increment on this edge would land on the limit
  assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: single-outstanding bridge from addr_decoder hits to a one-hot slave bus.
// Ack timeout is built only when PERIPH_BUS_TIMEOUT_EN is defined.
module periph_bus_ctrl
  import periph_bus_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [XLEN-1:0]            req_wdata,
  input  logic [3:0]                 req_be,
  output logic                       rsp_valid,
  output logic [XLEN-1:0]            rsp_rdata,
  output logic                       rsp_err,
  input  logic                       data_mem_en,
  input  logic [XLEN-1:0]            data_mem_addr,
  input  logic                       uart0_addr_en,
  input  logic [XLEN-1:0]            uart0_addr,
  input  logic                       gpio0_addr_en,
  input  logic [XLEN-1:0]            gpio0_addr,
  output logic [NUM_SLAVES-1:0]      slv_sel,
  output logic [XLEN-1:0]            slv_addr,
  output logic                       slv_we,
  output logic [XLEN-1:0]            slv_wdata,
  output logic [3:0]                 slv_be,
  input  logic [NUM_SLAVES-1:0]      slv_ack,
  input  logic [NUM_SLAVES*XLEN-1:0] slv_rdata
);
  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [XLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d, err_q, err_d, hit, ack_hit, expired;
  assign hit       = data_mem_en | uart0_addr_en | gpio0_addr_en;
  assign ack_hit   = |(slv_ack & sel_q);
  assign sel_rdata = sel_q[SLV_DMEM]  ? slv_rdata[SLV_DMEM*XLEN +: XLEN] :
                     sel_q[SLV_UART0] ? slv_rdata[SLV_UART0*XLEN +: XLEN] :
                                        slv_rdata[SLV_GPIO0*XLEN +: XLEN];
`ifdef PERIPH_BUS_TIMEOUT_EN
  bus_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == ST_RESP),
    .en     (state_q == ST_ACCESS),
    .expired(expired)
  );
`else
  assign expired = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d    = req_we;
        wdata_d = req_wdata;
        be_d    = req_be;
        sel_d   = data_mem_en ? 3'b001 : uart0_addr_en ? 3'b010 : gpio0_addr_en ? 3'b100 : 3'b000;
        addr_d  = data_mem_en ? data_mem_addr : uart0_addr_en ? uart0_addr :
                  gpio0_addr_en ? gpio0_addr : addr_q;
        err_d   = hit ? err_q : 1'b1;
        rdata_d = hit ? rdata_q : '0;
        state_d = hit ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: if (ack_hit || expired) begin
        // an ack on the expiring edge still yields a normal response
        err_d   = !ack_hit;
        rdata_d = (ack_hit && !we_q) ? sel_rdata : '0;
        sel_d   = '0;
        we_d    = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        sel_d   = '0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign req_ready = state_q == ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign slv_sel   = sel_q;
  assign slv_addr  = addr_q;
  assign slv_we    = we_q;
  assign slv_wdata = wdata_q;
  assign slv_be    = be_q;
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: directed transactions against a cycle-level expectation model of periph_bus_ctrl.
module tb_periph_bus_ctrl;
  localparam int XLEN = 32;
  localparam int TO   = 16;
`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_err, slv_we;
  logic [XLEN-1:0] req_wdata, rsp_rdata, slv_addr, slv_wdata;
  logic [3:0] req_be, slv_be;
  logic data_mem_en, uart0_addr_en, gpio0_addr_en;
  logic [XLEN-1:0] data_mem_addr, uart0_addr, gpio0_addr;
  logic [2:0] slv_sel, slv_ack;
  logic [3*XLEN-1:0] slv_rdata;
  logic [XLEN-1:0] dm_rd = 32'hDEADBEEF, ua_rd = 32'h5A5A1234, gp_rd = 32'h0BADF00D;
  logic m_ready, m_rsp_valid, m_err, m_we;
  logic [2:0] m_sel;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_be;
  bit chk_en = 1'b0;
  int vecs = 0, miss = 0, cyc = 0, rsp_cyc = 0, acc_cyc = 0;

  periph_bus_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .data_mem_en(data_mem_en), .data_mem_addr(data_mem_addr),
    .uart0_addr_en(uart0_addr_en), .uart0_addr(uart0_addr), .gpio0_addr_en(gpio0_addr_en),
    .gpio0_addr(gpio0_addr), .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_we(slv_we),
    .slv_wdata(slv_wdata), .slv_be(slv_be), .slv_ack(slv_ack), .slv_rdata(slv_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rsp_valid) rsp_cyc = cyc;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] prio(input logic [2:0] en);
    return en[0] ? 3'b001 : en[1] ? 3'b010 : en[2] ? 3'b100 : 3'b000;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("slv_sel", 32'(slv_sel), 32'(m_sel));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (m_sel != 3'b000) begin
      chk("slv_addr", slv_addr, m_addr);
      chk("slv_we", 32'(slv_we), 32'(m_we));
      chk("slv_wdata", slv_wdata, m_wdata);
      chk("slv_be", 32'(slv_be), 32'(m_be));
    end
  end

  task automatic drop_req();
    {data_mem_en, uart0_addr_en, gpio0_addr_en} = 3'b000;
    data_mem_addr = 32'hBAD00000;
    uart0_addr    = 32'hBAD00001;
    gpio0_addr    = 32'hBAD00002;
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic txn(input logic [2:0] en, input logic [XLEN-1:0] dm_a, ua_a, gp_a,
                     input logic we, input logic [XLEN-1:0] wd, input logic [3:0] be,
                     input int dly, input logic [2:0] stray, input logic hold);
    logic [2:0] s;
    logic err;
    int n;
    s = prio(en);
    slv_rdata = {gp_rd, ua_rd, dm_rd};
    {gpio0_addr_en, uart0_addr_en, data_mem_en} = en;
    data_mem_addr = dm_a;
    uart0_addr = ua_a;
    gpio0_addr = gp_a;
    req_valid = 1'b1;
    req_we = we;
    req_wdata = wd;
    req_be = be;
    @(posedge clk); #1;
    acc_cyc = cyc;
    drop_req();
    req_valid = hold;
    m_ready = 1'b0;
    if (s == 3'b000) begin
      req_valid = 1'b0;
      m_rsp_valid = 1'b1;
      m_err = 1'b1;
      m_rdata = '0;
    end else begin
      err = TO_EN && dly >= TO;
      n = err ? TO : dly + 1;
      m_sel = s;
      m_addr = s[0] ? dm_a : s[1] ? ua_a : gp_a;
      m_we = we;
      m_wdata = wd;
      m_be = be;
      for (int k = 0; k < n; k++) begin
        slv_ack = (k == dly) ? s : (stray & ~s);
        @(posedge clk); #1;
      end
      slv_ack = 3'b000;
      req_valid = 1'b0;
      m_sel = 3'b000;
      m_we = 1'b0;
      m_rsp_valid = 1'b1;
      m_err = err;
      m_rdata = (err || we) ? '0 : s[0] ? dm_rd : s[1] ? ua_rd : gp_rd;
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    m_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0; req_be = '0;
    slv_ack = 3'b000; slv_rdata = '0;
    drop_req();
    m_ready = 1'b1; m_rsp_valid = 1'b0; m_err = 1'b0; m_we = 1'b0;
    m_sel = 3'b000; m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
    #3;
    chk("reset_sel", 32'(slv_sel), 32'h0);
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_addr", slv_addr, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", 32'(rsp_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    // dmem read, ack two cycles after select
    txn(3'b001, 32'h10, 32'h0, 32'h0, 1'b0, 32'h0, 4'hF, 2, 3'b000, 1'b0);
    chk("lit_dmem_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("lit_dmem_lat", 32'(rsp_cyc - acc_cyc), 32'd3);
    // uart0 write, immediate ack: two edges total
    txn(3'b010, 32'h0, 32'h4, 32'h0, 1'b1, 32'h41, 4'b0001, 0, 3'b000, 1'b0);
    chk("lit_uart_wr_rdata", rsp_rdata, 32'h0);
    chk("lit_uart_wr_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
    // unmapped
    txn(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 4'hF, 0, 3'b000, 1'b0);
    chk("lit_unmapped_err", 32'(rsp_err), 32'h1);
    chk("lit_unmapped_lat", 32'(rsp_cyc - acc_cyc), 32'd0);
    // gpio0 with ack only at cycle 40: times out first when the counter is built
    txn(3'b100, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0, 4'hF, 40, 3'b000, 1'b0);
    chk("lit_gpio_slow_err", 32'(rsp_err), TO_EN ? 32'h1 : 32'h0);
    chk("lit_gpio_slow_lat", 32'(rsp_cyc - acc_cyc), TO_EN ? 32'd16 : 32'd41);
    // ack on the last allowed cycle wins over the timeout
    txn(3'b100, 32'h0, 32'h0, 32'h24, 1'b0, 32'h0, 4'hF, TO - 1, 3'b000, 1'b0);
    chk("lit_boundary_err", 32'(rsp_err), 32'h0);
    chk("lit_boundary_rdata", rsp_rdata, 32'h0BADF00D);
    // priority dmem over gpio0, stray gpio ack ignored, req_valid held during access
    txn(3'b101, 32'h30, 32'h0, 32'h34, 1'b0, 32'h0, 4'hF, 3, 3'b100, 1'b1);
    chk("lit_prio_rdata", rsp_rdata, 32'hDEADBEEF);
    // uart0 read with strays from both other slaves
    txn(3'b110, 32'h0, 32'h8, 32'h3C, 1'b0, 32'h0, 4'b0011, 1, 3'b101, 1'b0);
    // back-to-back gpio0 write
    txn(3'b100, 32'h0, 32'h0, 32'h40, 1'b1, 32'hCAFE0001, 4'b1100, 1, 3'b011, 1'b0);
    // reset in the middle of an access
    {gpio0_addr_en, uart0_addr_en, data_mem_en} = 3'b100;
    gpio0_addr = 32'h44;
    req_valid = 1'b1; req_we = 1'b0; req_wdata = 32'h0; req_be = 4'hF;
    @(posedge clk); #1;
    drop_req();
    req_valid = 1'b0;
    m_ready = 1'b0; m_sel = 3'b100; m_addr = 32'h44; m_we = 1'b0; m_wdata = 32'h0; m_be = 4'hF;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", 32'(slv_sel), 32'h0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1; m_sel = 3'b000; m_rsp_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    dm_rd = 32'h12345678;
    txn(3'b001, 32'h50, 32'h0, 32'h0, 1'b0, 32'h0, 4'hF, 0, 3'b000, 1'b0);
    chk("lit_after_rst_rdata", rsp_rdata, 32'h12345678);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
Sits directly downstream of addr_decoder, between the core load/store path and the memory-mapped slaves: boot RAM, UART0 and GPIO0. Accepts one request at a time and converts the decoder's enable/offset outputs into a one-hot slave select plus shared address, write data, write-enable and byte-enable lines. Waits for the selected slave's ack, muxes its read data back to the core, and returns a bus error for unmapped addresses or (optionally) timeouts.

Parameters:
XLEN, 32, data/address width; matches the core XLEN.
TIMEOUT_CYCLES, 16, number of ACCESS cycles without ack before a bus error is raised; must be >= 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  block can accept a request; high only in IDLE
req_we  input  1  1 = write, 0 = read
req_wdata  input  XLEN  write data
req_be  input  4  byte enables
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  XLEN  read data; 0 for writes and errors
rsp_err  output  1  bus error, qualified by rsp_valid
data_mem_en / data_mem_addr  input  1 / XLEN  decoder boot-RAM hit and offset
uart0_addr_en / uart0_addr  input  1 / XLEN  decoder UART0 hit and offset
gpio0_addr_en / gpio0_addr  input  1 / XLEN  decoder GPIO0 hit and offset
slv_sel  output  3  one-hot select: bit0 = dmem, bit1 = uart0, bit2 = gpio0
slv_addr / slv_we / slv_wdata / slv_be  output  XLEN / 1 / XLEN / 4  shared slave request lines
slv_ack  input  3  per-slave ack, same bit order as slv_sel
slv_rdata  input  3*XLEN  packed read data; slave i occupies bits [i*XLEN +: XLEN]

Behaviour:
- Reset (async, rst_n=0): state IDLE. slv_sel, slv_addr, slv_we, slv_wdata, slv_be, rsp_valid, rsp_rdata, rsp_err and the timeout counter all 0. Selects drop immediately, including mid-access. req_ready=1 because it is decoded from IDLE.
- States:
  - IDLE: req_ready=1.
    - On req_valid at a clock edge, capture we/wdata/be.
    - Select by priority when more than one enable is high: dmem > uart0 > gpio0. Load slv_addr with the chosen decoder offset and go to ACCESS.
    - If no enable is high: slv_sel stays 0, latch err=1 and rdata=0, go to RESP.
  - ACCESS: slv_sel and the shared lines are held stable.
    - If slv_ack[selected]=1, capture the selected slv_rdata (forced to 0 when writing) and go to RESP.
    - Acks from unselected slaves are ignored.
    - The timeout counter increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES with no ack, go to RESP with err=1 and rdata=0.
  - RESP: rsp_valid=1 for exactly one cycle; no back-pressure. On exit, clear slv_sel, slv_we and the counter, then go to IDLE.
- Latency: accept edge E0. slv_sel is high in the cycle after E0. If ack is sampled at edge En, rsp_valid is high for the cycle after En. Minimum accept-to-response is 2 edges.
- Unmapped access: rsp_valid in the cycle after the accept edge.
- rsp_rdata and rsp_err hold their values until the next RESP.
- Counter width: $clog2(TIMEOUT_CYCLES+1). An ack on the same edge the counter reaches its limit wins: normal response, err=0.
- req_valid is ignored outside IDLE.

Optional Feature:
PERIPH_BUS_TIMEOUT_EN
- Defined: timeout counter present; behaviour as above.
- Undefined: no counter; ACCESS waits for ack indefinitely; rsp_err is raised only for unmapped addresses.

Decomposition:
- Shared package (header_files/periph_bus.vh):
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - slave indices SLV_DMEM=0, SLV_UART0=1, SLV_GPIO0=2
  - NUM_SLAVES=3
- Sub-module: bus_timeout_cnt. Ports: clk, rst_n, clr, en; output expired. Parameter TIMEOUT_CYCLES. Instantiated only under PERIPH_BUS_TIMEOUT_EN.

Test Plan:
- Read dmem: data_mem_en=1, data_mem_addr=0x10; dmem ack 2 cycles after select with rdata 0xDEADBEEF -> slv_sel=3'b001, slv_addr=0x10, rsp_valid one cycle after ack, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write uart0: uart0_addr_en=1, uart0_addr=0x4, wdata=0x41, be=4'b0001, ack immediate -> slv_sel=3'b010, slv_we=1, slv_wdata=0x41, rsp_rdata=0, rsp_err=0; total 2 edges.
- Unmapped: all enables 0, req_valid=1 -> slv_sel never asserted; rsp_valid=1 with rsp_err=1 and rsp_rdata=0 in the cycle after accept.
- Timeout (macro defined, TIMEOUT_CYCLES=16): gpio0 select, no ack -> slv_sel=3'b100 for 16 cycles, then rsp_err=1 and slv_sel=0. With the macro undefined, sel is held until an ack arrives at cycle 40.
- Priority and stray ack: data_mem_en=1 and gpio0_addr_en=1 together -> slv_sel=3'b001. slv_ack=3'b100 is ignored; slv_ack=3'b001 completes the access.
- Reset mid-access: rst_n=0 while in ACCESS -> slv_sel=0 and rsp_valid=0 immediately; req_ready=1 after release; next request completes normally.
